// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA1 front end.
// The padder and the compute engine both use these block and word sizes.
package sha1_pkg;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_PAD  = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   localparam int SHA1_BLOCK_W = 512;
   localparam int SHA1_WORD_W  = 32;
   localparam int SHA1_WORDS   = 16;

   localparam logic [SHA1_WORD_W-1:0] SHA1_PAD_MARKER = 32'h80000000;

endpackage

// File: rtl/sha1_pad_lastword.sv
// Builds the final message word: keeps the top n bytes and appends the 0x80 marker.
// When the word is full (n>=4) the marker cannot fit and is flagged as pending.
module sha1_pad_lastword
   import sha1_pkg::*;
(
   input  logic [SHA1_WORD_W-1:0] data,
   input  logic [2:0]             n,
   output logic [SHA1_WORD_W-1:0] word,
   output logic                   marker_pending
);

   always_comb begin
      word           = data;
      marker_pending = 1'b0;
      case (n)
         3'd0:    word = SHA1_PAD_MARKER;
         3'd1:    word = {data[31:24], 24'h800000};
         3'd2:    word = {data[31:16], 16'h8000};
         3'd3:    word = {data[31:8], 8'h80};
         default: marker_pending = 1'b1;
      endcase
   end

endmodule

// File: rtl/sha1_pad.sv
// SHA1 message padder: collects 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha1_pad
   import sha1_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SHA1_WORD_W-1:0]  in_data,
   input  logic                    in_last,
   input  logic [2:0]              in_bytes,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SHA1_BLOCK_W-1:0] out_block,
   output logic                    out_first,
   output logic                    out_last,
   output logic                    busy,
   output logic                    err
);

   localparam logic [3:0] LAST_IDX = 4'(SHA1_WORDS - 1);

   state_t           state;
   logic [3:0]       idx;
   logic [LEN_W-1:0] len;
   logic             first;
   logic             lenblk;     // current block is the one that carries the length
   logic             pend;       // 0x80 marker still owed to the next pad word
   logic             pad_cont;   // after this emit, padding continues in a fresh block

   logic [2:0]             n_clamp;
   logic [SHA1_WORD_W-1:0] last_word;
   logic                   last_pend;
   logic [SHA1_WORD_W-1:0] pad_word;
   logic [63:0]            len64;

   assign n_clamp  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
   assign len64    = 64'(len);
   assign in_ready = (state == S_FILL) && !reset;
   assign busy     = (state != S_FILL) || (idx != 4'd0);

   sha1_pad_lastword u_lastword (
      .data           (in_data),
      .n              (n_clamp),
      .word           (last_word),
      .marker_pending (last_pend)
   );

   always_comb begin
      pad_word = '0;
      if (pend)
         pad_word = SHA1_PAD_MARKER;
      else if (lenblk && idx == 4'd14)
         pad_word = len64[63:32];
      else if (lenblk && idx == LAST_IDX)
         pad_word = len64[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FILL;
         idx       <= '0;
         len       <= '0;
         first     <= 1'b1;
         lenblk    <= 1'b0;
         pend      <= 1'b0;
         pad_cont  <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_block <= '0;
      end else begin
         case (state)
            S_FILL: begin
               if (in_valid) begin
                  idx <= idx + 4'd1;
                  if (!in_last) begin
                     out_block[idx*32 +: 32] <= in_data;
                     len <= len + LEN_W'(32);
                     if (idx == LAST_IDX) begin
                        state     <= S_EMIT;
                        out_valid <= 1'b1;
                        out_first <= first;
                        out_last  <= 1'b0;
                        pad_cont  <= 1'b0;
                     end
                  end else begin
                     if (in_bytes > 3'd4)
                        err <= 1'b1;
                     out_block[idx*32 +: 32] <= last_word;
                     len    <= len + LEN_W'({n_clamp, 3'b000});
                     pend   <= last_pend;
                     lenblk <= last_pend ? (idx <= 4'd12) : (idx <= 4'd13);
                     if (idx == LAST_IDX) begin
                        state     <= S_EMIT;
                        out_valid <= 1'b1;
                        out_first <= first;
                        out_last  <= 1'b0;
                        pad_cont  <= 1'b1;
                     end else begin
                        state <= S_PAD;
                     end
                  end
               end
            end
            S_PAD: begin
               out_block[idx*32 +: 32] <= pad_word;
               pend <= 1'b0;
               idx  <= idx + 4'd1;
               if (idx == LAST_IDX) begin
                  state     <= S_EMIT;
                  out_valid <= 1'b1;
                  out_first <= first;
                  out_last  <= lenblk;
                  pad_cont  <= !lenblk;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  first     <= out_last;
                  idx       <= '0;
                  pad_cont  <= 1'b0;
                  if (pad_cont) begin
                     state  <= S_PAD;
                     lenblk <= 1'b1;
                  end else begin
                     state <= S_FILL;
                  end
                  // A finished message restarts the length for the next one.
                  if (out_last) begin
                     len    <= '0;
                     lenblk <= 1'b0;
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_pad.sv
// Self-checking bench for sha1_pad: directed padding cases plus random messages
// checked against a byte-level FIPS padding model.
module tb_sha1_pad;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_block;
   logic         out_first;
   logic         out_last;
   logic         busy;
   logic         err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]   msg_q[$];
   logic [31:0]  wq_data[$];
   logic         wq_last[$];
   logic [2:0]   wq_bytes[$];
   logic [511:0] exp_blk[$];
   logic         exp_first[$];
   logic         exp_last[$];
   logic [511:0] got_blk[$];
   logic         got_first[$];
   logic         got_last[$];
   int           acc_cyc;
   int           seen_cyc;

   sha1_pad #(.LEN_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block),
      .out_first (out_first),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: pad the byte string per FIPS 180-4 and cut it into 64-byte blocks.
   task automatic build_expected();
      logic [7:0]   p[$];
      logic [63:0]  bitlen;
      logic [511:0] b;
      int           nb;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bitlen = 64'(msg_q.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
      nb = p.size() / 64;
      exp_blk.delete(); exp_first.delete(); exp_last.delete();
      for (int k = 0; k < nb; k++) begin
         b = '0;
         for (int w = 0; w < 16; w++)
            b[32*w +: 32] = {p[64*k+4*w], p[64*k+4*w+1], p[64*k+4*w+2], p[64*k+4*w+3]};
         exp_blk.push_back(b);
         exp_first.push_back(k == 0);
         exp_last.push_back(k == nb - 1);
      end
   endtask

   // Cut the message into input words; unused bytes are random garbage.
   task automatic make_words(input bit extra_empty);
      int L, nw, nbytes;
      logic [31:0] d;
      L  = msg_q.size();
      nw = (L + 3) / 4;
      if (nw == 0) nw = 1;
      wq_data.delete(); wq_last.delete(); wq_bytes.delete();
      for (int w = 0; w < nw; w++) begin
         d = $urandom;
         nbytes = (w == nw - 1) ? L - 4*w : 4;
         for (int j = 0; j < nbytes; j++) d[31-8*j -: 8] = msg_q[4*w+j];
         wq_data.push_back(d);
         wq_last.push_back(w == nw - 1);
         wq_bytes.push_back(3'(nbytes));
      end
      if (extra_empty && L > 0 && L % 4 == 0) begin
         wq_last[nw-1] = 1'b0;
         wq_data.push_back($urandom);
         wq_last.push_back(1'b1);
         wq_bytes.push_back(3'd0);
      end
   endtask

   task automatic rand_msg(input int len);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
   endtask

   // Drive the queued words and collect blocks until nexp blocks arrive.
   task automatic run(input int vpct, input int rpct, input int nexp);
      int wi;
      bit done;
      wi = 0; done = 0;
      acc_cyc = -1; seen_cyc = -1;
      got_blk.delete(); got_first.delete(); got_last.delete();
      for (int t = 0; t < 4000 && !done; t++) begin
         @(negedge clk);
         if (wi < wq_data.size() && int'($urandom % 100) < vpct) begin
            in_valid = 1'b1;
            in_data  = wq_data[wi];
            in_last  = wq_last[wi];
            in_bytes = wq_last[wi] ? wq_bytes[wi] : 3'($urandom);
         end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'b0;
            in_bytes = 3'($urandom);
         end
         out_ready = (int'($urandom % 100) < rpct);
         #1;
         if (out_valid && out_last && seen_cyc < 0) seen_cyc = cyc;
         if (in_valid && in_ready) begin
            if (wq_last[wi]) acc_cyc = cyc;
            wi++;
         end
         if (out_valid && out_ready) begin
            got_blk.push_back(out_block);
            got_first.push_back(out_first);
            got_last.push_back(out_last);
         end
         done = (wi == wq_data.size()) && (got_blk.size() >= nexp);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL run_timeout got_blocks=%0d need=%0d words_sent=%0d", got_blk.size(), nexp, wi);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_bytes = 3'd0;
      in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total += 7;
      if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      if (out_first !== 1'b0) begin bad++; $display("FAIL rst_out_first got=%b exp=0", out_first); end
      if (out_last !== 1'b0)  begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      if (out_block !== '0)   begin bad++; $display("FAIL rst_out_block got=%h exp=0", out_block); end
      if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (err !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_abc();
      logic [511:0] b;
      msg_q = '{8'h61, 8'h62, 8'h63};
      make_words(0);
      wq_data[0] = 32'h616263A5;  // garbage in the unused byte must be masked
      run(100, 100, 1);
      b = got_blk[0];
      total += 7;
      if (got_blk.size() != 1)   begin bad++; $display("FAIL abc_nblk got=%0d exp=1", got_blk.size()); end
      if (b[31:0] !== 32'h61626380)   begin bad++; $display("FAIL abc_word0 got=%h exp=61626380", b[31:0]); end
      if (b[479:32] !== '0)           begin bad++; $display("FAIL abc_words1_14 got=%h exp=0", b[479:32]); end
      if (b[511:480] !== 32'h00000018) begin bad++; $display("FAIL abc_word15 got=%h exp=00000018", b[511:480]); end
      if ({got_first[0], got_last[0]} !== 2'b11) begin bad++; $display("FAIL abc_flags got=%b%b exp=11", got_first[0], got_last[0]); end
      if (seen_cyc - acc_cyc != 16) begin bad++; $display("FAIL abc_latency got=%0d exp=16", seen_cyc - acc_cyc); end
      if (err !== 1'b0) begin bad++; $display("FAIL abc_err got=%b exp=0", err); end
      $display("test_abc block word0=%h word15=%h", b[31:0], b[511:480]);
   endtask

   task automatic test_empty();
      logic [511:0] e;
      msg_q.delete();
      make_words(0);
      run(100, 100, 1);
      e = '0; e[31:0] = 32'h80000000;
      total += 3;
      if (got_blk[0] !== e) begin bad++; $display("FAIL empty_block got=%h exp=%h", got_blk[0], e); end
      if ({got_first[0], got_last[0]} !== 2'b11) begin bad++; $display("FAIL empty_flags got=%b%b exp=11", got_first[0], got_last[0]); end
      if (err !== 1'b0) begin bad++; $display("FAIL empty_err got=%b exp=0", err); end
      $display("test_empty word0=%h", got_blk[0][31:0]);
   endtask

   task automatic test_56();
      rand_msg(56);
      build_expected();
      make_words(0);
      run(70, 60, 2);
      total += 7;
      if (got_blk[0][479:448] !== 32'h80000000) begin bad++; $display("FAIL b56_blk1_word14 got=%h exp=80000000", got_blk[0][479:448]); end
      if (got_blk[0][511:480] !== 32'h0) begin bad++; $display("FAIL b56_blk1_word15 got=%h exp=0", got_blk[0][511:480]); end
      if ({got_first[0], got_last[0]} !== 2'b10) begin bad++; $display("FAIL b56_blk1_flags got=%b%b exp=10", got_first[0], got_last[0]); end
      if (got_blk[1][479:0] !== '0) begin bad++; $display("FAIL b56_blk2_words0_14 got=%h exp=0", got_blk[1][479:0]); end
      if (got_blk[1][511:480] !== 32'h000001C0) begin bad++; $display("FAIL b56_blk2_word15 got=%h exp=000001c0", got_blk[1][511:480]); end
      if ({got_first[1], got_last[1]} !== 2'b01) begin bad++; $display("FAIL b56_blk2_flags got=%b%b exp=01", got_first[1], got_last[1]); end
      if (got_blk[0] !== exp_blk[0]) begin bad++; $display("FAIL b56_blk1_model got=%h exp=%h", got_blk[0], exp_blk[0]); end
      $display("test_56 blocks=%0d", got_blk.size());
   endtask

   task automatic test_55();
      rand_msg(55);
      build_expected();
      make_words(0);
      run(100, 100, 1);
      total += 6;
      if (got_blk.size() != 1) begin bad++; $display("FAIL b55_nblk got=%0d exp=1", got_blk.size()); end
      if (got_blk[0][423:416] !== 8'h80) begin bad++; $display("FAIL b55_word13_low got=%h exp=80", got_blk[0][423:416]); end
      if (got_blk[0][479:448] !== 32'h0) begin bad++; $display("FAIL b55_word14 got=%h exp=0", got_blk[0][479:448]); end
      if (got_blk[0][511:480] !== 32'h000001B8) begin bad++; $display("FAIL b55_word15 got=%h exp=000001b8", got_blk[0][511:480]); end
      if (got_blk[0] !== exp_blk[0]) begin bad++; $display("FAIL b55_model got=%h exp=%h", got_blk[0], exp_blk[0]); end
      if (seen_cyc - acc_cyc != 3) begin bad++; $display("FAIL b55_latency got=%0d exp=3", seen_cyc - acc_cyc); end
      $display("test_55 word15=%h", got_blk[0][511:480]);
   endtask

   task automatic test_64();
      rand_msg(64);
      build_expected();
      make_words(0);
      run(80, 70, 2);
      total += 5;
      if (got_blk[0] !== exp_blk[0]) begin bad++; $display("FAIL b64_data_block got=%h exp=%h", got_blk[0], exp_blk[0]); end
      if ({got_first[0], got_last[0]} !== 2'b10) begin bad++; $display("FAIL b64_blk1_flags got=%b%b exp=10", got_first[0], got_last[0]); end
      if (got_blk[1][31:0] !== 32'h80000000) begin bad++; $display("FAIL b64_blk2_word0 got=%h exp=80000000", got_blk[1][31:0]); end
      if (got_blk[1][511:480] !== 32'h00000200) begin bad++; $display("FAIL b64_blk2_word15 got=%h exp=00000200", got_blk[1][511:480]); end
      if ({got_first[1], got_last[1]} !== 2'b01) begin bad++; $display("FAIL b64_blk2_flags got=%b%b exp=01", got_first[1], got_last[1]); end
      $display("test_64 blocks=%0d", got_blk.size());
   endtask

   task automatic test_backpressure();
      logic [511:0] held;
      bit           ok;
      msg_q = '{8'h61, 8'h62, 8'h63};
      build_expected();
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h61626300; in_last = 1'b1; in_bytes = 3'd3; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         #1;
         ok = out_valid;
         if (!ok) @(negedge clk);
      end
      total++;
      if (!ok) begin bad++; $display("FAIL bp_wait_valid got=0 exp=1"); end
      held = out_block;
      total++;
      if (held !== exp_blk[0]) begin bad++; $display("FAIL bp_block got=%h exp=%h", held, exp_blk[0]); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total += 3;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%b exp=1", c, out_valid); end
         if (out_block !== held) begin bad++; $display("FAIL bp_stable_c%0d got=%h exp=%h", c, out_block, held); end
         if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready_c%0d got=%b exp=0", c, in_ready); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b exp=0", out_valid); end
      if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_resume got=%b exp=1", in_ready); end
      $display("test_backpressure held 5 cycles");
   endtask

   task automatic test_reset_mid_pad();
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h61626300; in_last = 1'b1; in_bytes = 3'd3;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL midpad_busy got=%b exp=1", busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midpad_rst_valid got=%b exp=0", out_valid); end
      if (busy !== 1'b0)      begin bad++; $display("FAIL midpad_rst_busy got=%b exp=0", busy); end
      msg_q = '{8'h61, 8'h62, 8'h63};
      build_expected();
      make_words(0);
      run(100, 100, 1);
      total += 2;
      if (got_blk[0] !== exp_blk[0]) begin bad++; $display("FAIL midpad_abc got=%h exp=%h", got_blk[0], exp_blk[0]); end
      if ({got_first[0], got_last[0]} !== 2'b11) begin bad++; $display("FAIL midpad_flags got=%b%b exp=11", got_first[0], got_last[0]); end
      $display("test_reset_mid_pad recovered");
   endtask

   task automatic test_err();
      rand_msg(4);
      build_expected();
      make_words(0);
      wq_bytes[0] = 3'd7;
      run(100, 100, 1);
      total += 2;
      if (got_blk[0] !== exp_blk[0]) begin bad++; $display("FAIL err_block got=%h exp=%h", got_blk[0], exp_blk[0]); end
      if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
      $display("test_err err flag exercised");
   endtask

   task automatic test_random();
      int len;
      for (int m = 0; m < 20; m++) begin
         len = $urandom_range(0, 200);
         rand_msg(len);
         build_expected();
         make_words($urandom % 2 == 1);
         run($urandom_range(30, 100), $urandom_range(30, 100), exp_blk.size());
         total++;
         if (got_blk.size() != exp_blk.size()) begin
            bad++; $display("FAIL rnd%0d_nblk got=%0d exp=%0d", m, got_blk.size(), exp_blk.size());
         end
         for (int i = 0; i < exp_blk.size(); i++) begin
            total += 2;
            if (got_blk[i] !== exp_blk[i]) begin
               bad++; $display("FAIL rnd%0d_blk%0d got=%h exp=%h", m, i, got_blk[i], exp_blk[i]);
            end
            if ({got_first[i], got_last[i]} !== {exp_first[i], exp_last[i]}) begin
               bad++; $display("FAIL rnd%0d_flags%0d got=%b%b exp=%b%b", m, i, got_first[i], got_last[i], exp_first[i], exp_last[i]);
            end
         end
         $display("test_random msg=%0d len=%0d blocks=%0d", m, len, got_blk.size());
      end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", err); end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_56();
      test_55();
      test_64();
      test_backpressure();
      test_reset_mid_pad();
      test_err();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
